// File: rtl/rca_pkg.sv
// Shared constants for the digit-serial adder scheduler: FSM encoding,
// digit width and requester ID width.
package rca_pkg;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam int DIGIT_W = 4;
   localparam int ID_W    = 1;

   typedef logic [DIGIT_W-1:0] digit_t;

endpackage

// File: rtl/rca_seq_sched_rca4bit.sv
// 4-bit ripple-carry adder cell; the single shared datapath slice of the
// scheduler.
module RCA4Bit
   import rca_pkg::*;
(
   input  logic [DIGIT_W-1:0] i_a,
   input  logic [DIGIT_W-1:0] i_b,
   input  logic               i_cin,
   output logic [DIGIT_W-1:0] o_sum,
   output logic               o_cout
);

   logic [DIGIT_W:0] w_c;

   assign w_c[0] = i_cin;

   for (genvar gi = 0; gi < DIGIT_W; gi++) begin : g_fa
      assign o_sum[gi]   = i_a[gi] ^ i_b[gi] ^ w_c[gi];
      assign w_c[gi + 1] = (i_a[gi] & i_b[gi]) | (w_c[gi] & (i_a[gi] ^ i_b[gi]));
   end

   assign o_cout = w_c[DIGIT_W];

endmodule

// File: rtl/rca_seq_sched.sv
// Round-robin scheduler sharing one 4-bit RCA slice between two requesters;
// each accepted add is walked LSB-nibble first with the carry held in a register.
module rca_seq_sched
   import rca_pkg::*;
#(
   parameter  int WIDTH = 32,
   localparam int NDIG  = WIDTH / DIGIT_W
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req0_cin,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic             req1_cin,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_sum,
   output logic             rsp_cout,
   output logic             rsp_id,
   output logic             busy
);

   localparam int CNT_W = $clog2(NDIG);

   logic [1:0]       r_state;
   logic             r_last_grant;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_carry;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic [ID_W-1:0]  r_id;

   logic   w_idle;
   logic   w_run;
   logic   w_grant0;
   logic   w_grant1;
   logic   w_acc0;
   logic   w_acc1;
   logic   w_accept;
   logic   w_last_dig;
   digit_t w_a_dig;
   digit_t w_b_dig;
   digit_t w_s_dig;
   logic   w_c_out;
   digit_t w_a_digs [NDIG];
   digit_t w_b_digs [NDIG];

   assign w_idle = (r_state == IDLE);
   assign w_run  = (r_state == RUN);

   // On a tie the requester that did not win last time gets the slot.
   assign w_grant0 = req0_valid & (~req1_valid | r_last_grant);
   assign w_grant1 = req1_valid & (~req0_valid | ~r_last_grant);

   assign req0_ready = rst_n & w_idle & w_grant0;
   assign req1_ready = rst_n & w_idle & w_grant1;

   assign w_acc0   = req0_valid & req0_ready;
   assign w_acc1   = req1_valid & req1_ready;
   assign w_accept = w_acc0 | w_acc1;

   for (genvar gi = 0; gi < NDIG; gi++) begin : g_dig
      assign w_a_digs[gi] = r_a[gi*DIGIT_W +: DIGIT_W];
      assign w_b_digs[gi] = r_b[gi*DIGIT_W +: DIGIT_W];
   end

   assign w_a_dig    = w_a_digs[r_cnt];
   assign w_b_dig    = w_b_digs[r_cnt];
   assign w_last_dig = (r_cnt == CNT_W'(NDIG - 1));

   RCA4Bit u_slice (
      .i_a    (w_a_dig),
      .i_b    (w_b_dig),
      .i_cin  (r_carry),
      .o_sum  (w_s_dig),
      .o_cout (w_c_out)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_last_grant <= 1'b1;
         r_cnt        <= '0;
         r_a          <= '0;
         r_b          <= '0;
         r_carry      <= 1'b0;
         r_sum        <= '0;
         r_cout       <= 1'b0;
         r_id         <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_a          <= w_acc1 ? req1_a   : req0_a;
                  r_b          <= w_acc1 ? req1_b   : req0_b;
                  r_carry      <= w_acc1 ? req1_cin : req0_cin;
                  r_id         <= ID_W'(w_acc1);
                  r_last_grant <= w_acc1;
                  r_cnt        <= '0;
                  r_sum        <= '0;
                  r_state      <= RUN;
               end
            end
            RUN: begin
               for (int k = 0; k < NDIG; k++) begin
                  if (r_cnt == CNT_W'(k)) begin
                     r_sum[k*DIGIT_W +: DIGIT_W] <= w_s_dig;
                  end
               end
               r_carry <= w_c_out;
               r_cnt   <= r_cnt + CNT_W'(1);
               if (w_last_dig) begin
                  r_cout  <= w_c_out;
                  r_state <= DONE;
               end
            end
            DONE: begin
               if (rsp_ready) begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign rsp_valid = (r_state == DONE);
   assign rsp_sum   = r_sum;
   assign rsp_cout  = r_cout;
   assign rsp_id    = r_id;
   assign busy      = w_run | rsp_valid;

endmodule
